// File: rtl/apb4_sram_ctrl_if.sv
// APB4 signal bundle between a bus master (bridge or bench) and the SRAM controller.
interface apb4_sram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_sram_ctrl.sv
// APB4 slave in front of a DEPTH x DATA_WIDTH SRAM array: byte strobes, alignment and
// range checking, fixed wait states and abort handling. All outputs are registered.
module apb4_sram_ctrl #(
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    DEPTH            = 64,
  parameter int                    WAIT_CYCLES      = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL        = '0,
  parameter bit                    RESET_CLEARS_MEM = 1'b1
) (
  input logic             PCLK,
  input logic             PRESET,
  apb4_sram_ctrl_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]            WAIT_L    = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_full;
  logic [IDX_W-1:0]      idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  addr_err;
  logic                  setup;
  logic                  enter_done;
  logic                  commit;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [BYTES-1:0]      strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < BYTES; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode; PADDR is held stable by the master for the whole transfer.
  assign word_full    = bus.PADDR >> OFF;
  assign idx          = word_full[IDX_W-1:0];
  assign misaligned   = (bus.PADDR & LANE_MASK) != '0;
  assign out_of_range = {1'b0, word_full} >= DEPTH_L;
  assign addr_err     = misaligned | out_of_range;

  assign setup      = bus.PSEL & ~bus.PENABLE;
  assign enter_done = ((state == S_IDLE) && setup && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && bus.PSEL && (cnt == 4'd1));
  assign commit     = (state == S_DONE) && bus.PSEL && bus.PENABLE && bus.PWRITE && !addr_err;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // A lone PENABLE without a setup phase is not a transfer and is ignored.
          if (setup) begin
            cnt   <= WAIT_L;
            state <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.PSEL) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (enter_done) begin
        pready_q  <= 1'b1;
        pslverr_q <= addr_err;
        if (!bus.PWRITE) prdata_q <= addr_err ? '0 : mem[idx];
      end
    end
  end

  // Writes land on the DONE exit edge, so a following read always sees them.
  generate
    if (RESET_CLEARS_MEM) begin : g_mem_clear
      always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (commit) begin
          mem[idx] <= merge_lanes(mem[idx], bus.PWDATA, bus.PSTRB);
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge PCLK) begin
        if (commit) mem[idx] <= merge_lanes(mem[idx], bus.PWDATA, bus.PSTRB);
      end
    end
  endgenerate

  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb4_sram_ctrl.sv
// Bench for apb4_sram_ctrl: a 32-bit/2-wait instance and a 64-bit/0-wait instance
// driven through one APB master, checked against vector tables and an array model.
module tb_apb4_sram_ctrl;
  localparam int DEPTH_A = 64;
  localparam int DEPTH_B = 16;
  localparam int WAIT_A  = 2;
  localparam int WAIT_B  = 0;
  localparam logic [63:0] RVAL_B = 64'hA5A5A5A5_5A5A5A5A;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  logic        sel;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic        pready_m, pslverr_m;
  logic [63:0] prdata_m;

  apb4_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  apb4_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) ifb ();

  assign ifa.PSEL    = psel & ~sel;
  assign ifa.PENABLE = penable;
  assign ifa.PWRITE  = pwrite;
  assign ifa.PADDR   = paddr;
  assign ifa.PWDATA  = pwdata[31:0];
  assign ifa.PSTRB   = pstrb[3:0];
  assign ifb.PSEL    = psel & sel;
  assign ifb.PENABLE = penable;
  assign ifb.PWRITE  = pwrite;
  assign ifb.PADDR   = paddr;
  assign ifb.PWDATA  = pwdata;
  assign ifb.PSTRB   = pstrb;

  assign pready_m  = sel ? ifb.PREADY  : ifa.PREADY;
  assign pslverr_m = sel ? ifb.PSLVERR : ifa.PSLVERR;
  assign prdata_m  = sel ? ifb.PRDATA  : {32'b0, ifa.PRDATA};

  apb4_sram_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A),
    .RESET_VAL(32'h0), .RESET_CLEARS_MEM(1'b1)
  ) dut_a (.PCLK(clk), .PRESET(rst_a), .bus(ifa));

  apb4_sram_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B),
    .RESET_VAL(RVAL_B), .RESET_CLEARS_MEM(1'b1)
  ) dut_b (.PCLK(clk), .PRESET(rst_b), .bus(ifb));

  int nvec = 0;
  int nmis = 0;

  logic [31:0] mem_a [DEPTH_A];
  logic [63:0] mem_b [DEPTH_B];
  logic [63:0] last_rd [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic model_reset(input bit which);
    if (which) for (int i = 0; i < DEPTH_B; i++) mem_b[i] = RVAL_B;
    else       for (int i = 0; i < DEPTH_A; i++) mem_a[i] = 32'h0;
    last_rd[which] = 64'h0;
  endtask

  // Reference behaviour: byte-addressed word array, error on misalignment or overrun.
  task automatic model_xfer(input bit which, input bit w, input logic [31:0] addr,
                            input logic [63:0] data, input logic [7:0] strb,
                            output logic [63:0] erd, output bit eerr);
    int unsigned bytes, depth, idx;
    logic [63:0] word;
    bytes = which ? 8 : 4;
    depth = which ? DEPTH_B : DEPTH_A;
    eerr  = (addr % bytes != 0) || (addr / bytes >= depth);
    idx   = addr / bytes;
    word  = 64'h0;
    if (!eerr) word = which ? mem_b[idx] : {32'b0, mem_a[idx]};
    if (w) begin
      if (!eerr) begin
        for (int b = 0; b < 8; b++)
          if (b < bytes && strb[b]) word[8*b +: 8] = data[8*b +: 8];
        if (which) mem_b[idx] = word;
        else       mem_a[idx] = word[31:0];
      end
      erd = last_rd[which];
    end else begin
      erd = word;
      last_rd[which] = word;
    end
  endtask

  // One APB transfer; returns at the negedge inside the PREADY cycle, PSEL still high.
  task automatic apb(input bit which, input bit w, input logic [31:0] addr,
                     input logic [63:0] data, input logic [7:0] strb,
                     output logic [63:0] rd, output logic err, output int ncyc);
    bit got;
    got = 1'b0;
    ncyc = 0;
    @(negedge clk);
    sel = which; psel = 1'b1; penable = 1'b0; pwrite = w;
    paddr = addr; pwdata = data; pstrb = strb;
    #1 chk("pready_in_setup", pready_m, 64'd0);
    @(negedge clk);
    penable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      ncyc = k;
      if (pready_m) begin
        got = 1'b1;
        break;
      end
      chk("pslverr_while_busy", pslverr_m, 64'd0);
      @(negedge clk);
    end
    if (!got) chk("pready_timeout", 64'd0, 64'd1);
    rd  = prdata_m;
    err = pslverr_m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic xfer_check(input bit which, input bit w, input logic [31:0] addr,
                            input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] rd, erd;
    logic        err;
    bit          eerr;
    int          ncyc;
    apb(which, w, addr, data, strb, rd, err, ncyc);
    model_xfer(which, w, addr, data, strb, erd, eerr);
    chk($sformatf("model_prdata_%s_%h", which ? "b" : "a", addr), rd, erd);
    chk($sformatf("model_pslverr_%s_%h", which ? "b" : "a", addr), err, eerr);
    chk("model_cycles", ncyc, which ? WAIT_B + 1 : WAIT_A + 1);
  endtask

  typedef struct {
    bit          which;
    bit          w;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic [63:0] rd, erd;
    logic        err;
    bit          eerr;
    int          ncyc;
    bit          which, w;
    logic [31:0] addr;
    int unsigned bytes, depth;

    sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    model_reset(1'b0); model_reset(1'b1);

    tbl[0]  = '{1'b0, 1'b1, 32'h08,  64'hDEADBEEF,            8'h0F, 64'h0,                   1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h08,  64'h0,                   8'h00, 64'hDEADBEEF,            1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h08,  64'h11223344,            8'h05, 64'hDEADBEEF,            1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h08,  64'h0,                   8'h0F, 64'hDE22BE44,            1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h100, 64'hCAFEF00D,            8'h0F, 64'hDE22BE44,            1'b1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0A,  64'h0,                   8'h00, 64'h0,                   1'b1};
    tbl[6]  = '{1'b0, 1'b0, 32'h08,  64'h0,                   8'h00, 64'hDE22BE44,            1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'hFC,  64'h0,                   8'h00, 64'h0,                   1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h78,  64'h0,                   8'h00, RVAL_B,                  1'b0};
    tbl[9]  = '{1'b1, 1'b1, 32'h00,  64'h01234567_89ABCDEF,   8'hFF, RVAL_B,                  1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h08,  64'hFEDCBA98_76543210,   8'hFF, RVAL_B,                  1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h00,  64'h0,                   8'h00, 64'h01234567_89ABCDEF,   1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h08,  64'h0,                   8'h00, 64'hFEDCBA98_76543210,   1'b0};
    tbl[13] = '{1'b1, 1'b1, 32'h00,  64'hFFFFFFFF_FFFFFFFF,   8'h0F, 64'hFEDCBA98_76543210,   1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'h00,  64'h0,                   8'h00, 64'h01234567_FFFFFFFF,   1'b0};
    tbl[15] = '{1'b1, 1'b1, 32'h04,  64'h11111111_11111111,   8'hFF, 64'h01234567_FFFFFFFF,   1'b1};
    tbl[16] = '{1'b1, 1'b1, 32'h00,  64'h0,                   8'h00, 64'h01234567_FFFFFFFF,   1'b0};
    tbl[17] = '{1'b1, 1'b0, 32'h00,  64'h0,                   8'h00, 64'h01234567_FFFFFFFF,   1'b0};
    tbl[18] = '{1'b1, 1'b0, 32'h80,  64'h0,                   8'h00, 64'h0,                   1'b1};
    tbl[19] = '{1'b1, 1'b0, 32'h08,  64'h0,                   8'h00, 64'hFEDCBA98_76543210,   1'b0};

    repeat (3) @(negedge clk);
    chk("reset_a_pready",  ifa.PREADY,  64'd0);
    chk("reset_a_pslverr", ifa.PSLVERR, 64'd0);
    chk("reset_a_prdata",  ifa.PRDATA,  64'd0);
    chk("reset_b_pready",  ifb.PREADY,  64'd0);
    chk("reset_b_prdata",  ifb.PRDATA,  64'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 20; i++) begin
      apb(tbl[i].which, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].strb, rd, err, ncyc);
      chk($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_pslverr", i), err, tbl[i].exp_err);
      chk($sformatf("vec%0d_cycles", i), ncyc, tbl[i].which ? WAIT_B + 1 : WAIT_A + 1);
      model_xfer(tbl[i].which, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].strb, erd, eerr);
    end
    idle(2);

    // Abort: PSEL drops during the first wait cycle of a write.
    @(negedge clk);
    sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h04; pwdata = 64'h12345678; pstrb = 8'hF;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_pready", pready_m, 64'd0);
    end
    apb(1'b0, 1'b0, 32'h04, 64'h0, 8'h0, rd, err, ncyc);
    chk("abort_read_data", rd, 64'h0);
    chk("abort_read_err", err, 64'd0);
    model_xfer(1'b0, 1'b0, 32'h04, 64'h0, 8'h0, erd, eerr);
    idle(1);

    // Protocol violation: access phase with no setup phase must be ignored.
    @(negedge clk);
    sel = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 64'h77777777; pstrb = 8'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("noseup_no_pready", pready_m, 64'd0);
    end
    idle(1);
    xfer_check(1'b0, 1'b0, 32'h0C, 64'h0, 8'h0);

    // Asynchronous reset in the middle of a wait-stated write.
    xfer_check(1'b0, 1'b0, 32'h08, 64'h0, 8'h0);
    @(negedge clk);
    sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 64'h55AA55AA; pstrb = 8'hF;
    @(negedge clk);
    penable = 1'b1;
    #2 rst_a = 1'b1;
    #1;
    chk("async_rst_pready",  ifa.PREADY,  64'd0);
    chk("async_rst_pslverr", ifa.PSLVERR, 64'd0);
    chk("async_rst_prdata",  ifa.PRDATA,  64'd0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    rst_a = 1'b0;
    model_reset(1'b0);
    apb(1'b0, 1'b0, 32'h10, 64'h0, 8'h0, rd, err, ncyc);
    chk("post_rst_read_data", rd, 64'h0);
    chk("post_rst_read_err", err, 64'd0);
    chk("post_rst_cycles", ncyc, WAIT_A + 1);
    model_xfer(1'b0, 1'b0, 32'h10, 64'h0, 8'h0, erd, eerr);

    // Random traffic against the array model.
    for (int i = 0; i < 160; i++) begin
      which = 1'($urandom_range(0, 1));
      w     = 1'($urandom_range(0, 1));
      bytes = which ? 8 : 4;
      depth = which ? DEPTH_B : DEPTH_A;
      if ($urandom_range(0, 7) == 0) addr = $urandom_range(0, depth * bytes + 16);
      else                           addr = $urandom_range(0, depth - 1) * bytes;
      xfer_check(which, w, addr, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
